polyvec_compress_pack: RTL and testbench

POLYVEC_COMPRESS_PACK -- requirements
Module: polyvec_compress_pack

---
 rtl/polyvec_compress_pack_pkg.sv | 27 ++
 rtl/poly_compress10_lane.sv | 49 ++++
 rtl/polyvec_compress_pack.sv | 141 ++++++++++++++
 tb/tb_polyvec_compress_pack.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polyvec_compress_pack_pkg.sv
// Shared constants for the Kyber polyvec 10-bit compress-and-pack datapath.
// Contents: modulus, rounding constant, lane/group/word/accumulator widths and
// the reciprocal used to replace the divide by KYBER_Q.
package polyvec_compress_pack_pkg;

    localparam int unsigned KYBER_Q     = 3329;
    localparam int unsigned ROUND_C     = 1664;
    localparam int unsigned COEFF_W     = 12;
    localparam int unsigned CMP_W       = 10;
    localparam int unsigned LANES       = 4;
    localparam int unsigned GROUP_W     = LANES * CMP_W;     // 40
    localparam int unsigned WORD_W      = 64;
    localparam int unsigned ACC_W       = 128;
    localparam int unsigned FILL_W      = 8;                 // must hold 0..128
    localparam int unsigned FILL_MAX_IN = ACC_W - GROUP_W;   // 88

    // x'*1024 + 1664 <= 3409536 fits in 22 bits.
    localparam int unsigned SCALED_W    = 22;

    // floor(n/3329) == (n * RECIP_M) >> RECIP_SHIFT for every n < 2^22:
    // 2^34 = 3329*5160669 + 2083, so RECIP_M*3329 - 2^34 = 1246 and
    // 1246 * 3409536 < 2^34, which keeps the truncation error below 1/3329.
    localparam int unsigned RECIP_M     = 5160670;
    localparam int unsigned RECIP_SHIFT = 34;
    localparam int unsigned PROD_W      = 45;

endpackage

// File: rtl/poly_compress10_lane.sv
// One coefficient lane: reduce mod Q and scale (S1), then reciprocal-multiply
// quotient (S2), giving round(x*1024/Q) mod 1024.
// Ports: clk, rst_n; s1_en/s2_en load the S1/S2 registers; x is the 12-bit
// input coefficient; c is the registered 10-bit compressed value.
module poly_compress10_lane
    import polyvec_compress_pack_pkg::*;
#(
    parameter int unsigned Q = KYBER_Q
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s1_en,
    input  logic               s2_en,
    input  logic [COEFF_W-1:0] x,
    output logic [CMP_W-1:0]   c
);

    logic [COEFF_W-1:0]  x_red;
    logic [SCALED_W-1:0] scaled_d, scaled_q;
    logic [PROD_W-1:0]   prod;
    logic [CMP_W-1:0]    c_d, c_q;

    // S1 reduce/scale and S2 quotient; the cast to CMP_W is the mod 1024.
    always_comb begin
        x_red    = (x >= COEFF_W'(Q)) ? (x - COEFF_W'(Q)) : x;
        scaled_d = scaled_q;
        if (s1_en) begin
            scaled_d = {x_red, 10'b0} + SCALED_W'(ROUND_C);
        end
        prod = PROD_W'(scaled_q) * PROD_W'(RECIP_M);
        c_d  = c_q;
        if (s2_en) begin
            c_d = CMP_W'(prod >> RECIP_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scaled_q <= '0;
            c_q      <= '0;
        end else begin
            scaled_q <= scaled_d;
            c_q      <= c_d;
        end
    end

    assign c = c_q;

endmodule

// File: rtl/polyvec_compress_pack.sv
// Kyber polyvec compress (d=10) and LSB-first bit packer into 64-bit words.
// Ports: clk, rst_n (async, active-low);
//   in_valid/in_ready/in_coeffs[47:0]/in_last : four 12-bit coefficients per beat;
//   out_valid/out_ready/out_data[63:0]/out_last : packed little-endian words,
//   out_last marks the word that empties the packer at the end of a polynomial.
module polyvec_compress_pack
    import polyvec_compress_pack_pkg::*;
#(
    parameter int unsigned KYBER_Q = 3329,
    parameter int unsigned KYBER_K = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*COEFF_W-1:0]   in_coeffs,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_data,
    output logic                       out_last
);

    // A configuration with no polynomials never accepts input.
    localparam logic K_OK = (KYBER_K != 0);

    logic s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
    logic s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
    logic [ACC_W-1:0]  acc_d, acc_q, acc_after;
    logic [FILL_W-1:0] fill_d, fill_q, fill_after;
    logic flush_d, flush_q;
    logic out_valid_d, out_valid_q, out_last_d, out_last_q;
    logic [WORD_W-1:0] out_data_d, out_data_q;
    logic out_free, drain, pad, emit, emit_last;
    logic s3_take, s2_free, s2_load, s1_free, in_fire;
    logic [LANES-1:0][CMP_W-1:0] lane_c;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        poly_compress10_lane #(.Q(KYBER_Q)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .s1_en (in_fire),
            .s2_en (s2_load),
            .x     (in_coeffs[i*COEFF_W +: COEFF_W]),
            .c     (lane_c[i])
        );
    end

    // Packer, backpressure chain and output register next-state.
    always_comb begin
        out_free = !out_valid_q || out_ready;
        drain    = out_free && (fill_q >= FILL_W'(WORD_W));
        // Bits above fill are always zero, so the low word is already padded.
        pad      = out_free && flush_q && (fill_q != '0) && (fill_q < FILL_W'(WORD_W));
        emit     = drain || pad;

        acc_after  = acc_q;
        fill_after = fill_q;
        if (drain) begin
            acc_after  = acc_q >> WORD_W;
            fill_after = fill_q - FILL_W'(WORD_W);
        end else if (pad) begin
            acc_after  = '0;
            fill_after = '0;
        end
        emit_last = emit && flush_q && (fill_after == '0);

        // The next polynomial may not mix with a tail still awaiting its flush.
        s3_take = s2_valid_q && (fill_after <= FILL_W'(FILL_MAX_IN))
                  && (!flush_q || emit_last);
        s2_free = !s2_valid_q || s3_take;
        s2_load = s1_valid_q && s2_free;
        s1_free = !s1_valid_q || s2_free;

        in_ready = rst_n && K_OK && s1_free;
        in_fire  = in_valid && in_ready;

        s1_valid_d = s1_free ? in_fire : s1_valid_q;
        s1_last_d  = in_fire ? in_last : s1_last_q;
        s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
        s2_last_d  = s2_load ? s1_last_q : s2_last_q;

        acc_d  = acc_after;
        fill_d = fill_after;
        if (s3_take) begin
            acc_d  = acc_after | (ACC_W'(lane_c) << fill_after);
            fill_d = fill_after + FILL_W'(GROUP_W);
        end

        flush_d = flush_q;
        if (emit_last) begin
            flush_d = 1'b0;
        end
        if (s3_take && s2_last_q) begin
            flush_d = 1'b1;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q[WORD_W-1:0];
            out_last_d  = emit_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            fill_q      <= '0;
            flush_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            flush_q     <= flush_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_polyvec_compress_pack.sv
// Self-checking bench for polyvec_compress_pack: lane arithmetic table,
// latency, flush padding, full polynomials, random backpressure, mid-run reset.
module tb_polyvec_compress_pack;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_last   = 1'b0;
    logic [47:0] in_coeffs = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
    logic [63:0] out_data;

    polyvec_compress_pack #(.KYBER_Q(3329), .KYBER_K(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeffs (in_coeffs),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        logic [3:0][11:0] x;
        logic [3:0][9:0]  c;
    } vec_t;

    exp_t        exp_q[$];
    int          tests      = 0;
    int          fails      = 0;
    int          words_seen = 0;
    bit          sb_en      = 1'b0;
    bit          rand_ready = 1'b0;
    logic [47:0] poly_mem [0:63];
    vec_t        vecs [6];

    function automatic logic [9:0] model_c(input logic [11:0] x);
        int unsigned xr;
        int unsigned q;
        xr = 32'(x);
        if (xr >= 3329) xr = xr - 3329;
        q = (xr * 1024 + 1664) / 3329;
        return 10'(q % 1024);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Bit-serial reference packer for poly_mem[0..n-1]; appends to exp_q.
    task automatic model_poly(input int n);
        logic [63:0] w;
        logic [63:0] pend;
        bit          have;
        int          nb;
        logic [9:0]  c;
        logic [47:0] beat;
        exp_t        e;
        w = '0; pend = '0; have = 1'b0; nb = 0;
        for (int i = 0; i < n; i++) begin
            beat = poly_mem[i];
            for (int l = 0; l < 4; l++) begin
                c = model_c(beat[l*12 +: 12]);
                for (int b = 0; b < 10; b++) begin
                    w[nb] = c[b];
                    nb++;
                    if (nb == 64) begin
                        if (have) begin e.d = pend; e.l = 1'b0; exp_q.push_back(e); end
                        pend = w; have = 1'b1; w = '0; nb = 0;
                    end
                end
            end
        end
        if (nb > 0) begin
            if (have) begin e.d = pend; e.l = 1'b0; exp_q.push_back(e); end
            e.d = w; e.l = 1'b1; exp_q.push_back(e);
        end else if (have) begin
            e.d = pend; e.l = 1'b1; exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [47:0] d, input logic l);
        int waitc;
        waitc = 0;
        in_valid = 1'b1; in_coeffs = d; in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitc++;
            if (waitc > 2000) begin
                tests++; fails++;
                $display("FAIL send_beat: in_ready stuck at 0, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drive_poly(input int n, input int stop_after);
        for (int i = 0; i < n && i < stop_after; i++) begin
            send_beat(poly_mem[i], (i == n - 1));
        end
    endtask

    task automatic rand_poly();
        for (int i = 0; i < 64; i++) begin
            poly_mem[i] = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                           12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words outstanding, required 0", exp_q.size());
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard and hold-under-stall monitor
    initial begin
        logic        stall_prev;
        logic [63:0] pd;
        logic        pl;
        exp_t        e;
        stall_prev = 1'b0; pd = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && sb_en) begin
                if (stall_prev) begin
                    tests++;
                    if (!out_valid || out_data !== pd || out_last !== pl) begin
                        fails++;
                        $display("FAIL hold: got v=%b %h last=%b, required v=1 %h last=%b",
                                 out_valid, out_data, out_last, pd, pl);
                    end
                end
                if (out_valid && out_ready) begin
                    words_seen++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL word: got unexpected %h last=%b, required none", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.d || out_last !== e.l) begin
                            fails++;
                            $display("FAIL word: got %h last=%b, required %h last=%b",
                                     out_data, out_last, e.d, e.l);
                        end
                    end
                end
            end
            stall_prev = rst_n && out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        exp_t e;

        vecs[0].x = {12'd1664, 12'd2,    12'd1,    12'd0};
        vecs[0].c = {10'd512,  10'd1,    10'd0,    10'd0};
        vecs[1].x = {12'd100,  12'd4095, 12'd3329, 12'd3328};
        vecs[1].c = {10'd31,   10'd236,  10'd0,    10'd0};
        vecs[2].x = {12'd0,    12'd4095, 12'd1664, 12'd3000};
        vecs[2].c = {10'd0,    10'd236,  10'd512,  10'd923};
        vecs[3].x = {12'd1664, 12'd1664, 12'd1664, 12'd1664};
        vecs[3].c = {10'd512,  10'd512,  10'd512,  10'd512};
        vecs[4].x = {12'd2,    12'd3329, 12'd3328, 12'd4095};
        vecs[4].c = {10'd1,    10'd0,    10'd0,    10'd236};
        vecs[5].x = {12'd4094, 12'd1663, 12'd1665, 12'd3330};
        vecs[5].c = {10'd235,  10'd512,  10'd512,  10'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_last",  64'(out_last),  64'd0);
        check("rst out_data",  out_data,       64'd0);
        check("rst in_ready",  64'(in_ready),  64'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        // Lane arithmetic: one-beat polynomial gives a single padded last word
        for (int i = 0; i < 6; i++) begin
            send_beat(vecs[i].x, 1'b1);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            check($sformatf("lane_vec%0d valid", i), 64'(out_valid), 64'd1);
            check($sformatf("lane_vec%0d data", i),  out_data, {24'h0, vecs[i].c});
            check($sformatf("lane_vec%0d last", i),  64'(out_last), 64'd1);
            @(posedge clk);
            #1;
        end

        // Latency: first word visible 3 edges after the second beat is accepted
        send_beat({4{12'd1664}}, 1'b0);
        send_beat({4{12'd1664}}, 1'b0);
        check("latency +0 valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("latency +1 valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("latency +2 valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("latency +3 valid", 64'(out_valid), 64'd1);
        check("latency +3 data",  out_data, 64'h0802008020080200);
        check("latency +3 last",  64'(out_last), 64'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Three beats of 1664: full word, then 56-bit padded last word
        sb_en = 1'b1;
        e.d = 64'h0802008020080200; e.l = 1'b0; exp_q.push_back(e);
        e.d = 64'h0080200802008020; e.l = 1'b1; exp_q.push_back(e);
        send_beat({4{12'd1664}}, 1'b0);
        send_beat({4{12'd1664}}, 1'b0);
        send_beat({4{12'd1664}}, 1'b1);
        wait_drain(200);

        // Full random polynomial, no stalls
        rand_poly();
        model_poly(64);
        w0 = words_seen;
        drive_poly(64, 64);
        wait_drain(500);
        check("poly64 word count", 64'(words_seen - w0), 64'd40);

        // 128 beats under random backpressure
        rand_ready = 1'b1;
        w0 = words_seen;
        for (int p = 0; p < 2; p++) begin
            rand_poly();
            model_poly(64);
            drive_poly(64, 64);
        end
        wait_drain(2000);
        check("backpressure word count", 64'(words_seen - w0), 64'd80);
        rand_ready = 1'b0;

        // Reset mid-polynomial, then a fresh polynomial
        sb_en = 1'b0;
        rand_poly();
        drive_poly(64, 30);
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 64'(out_valid), 64'd0);
        check("mid reset in_ready",  64'(in_ready),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        rand_poly();
        model_poly(64);
        w0 = words_seen;
        drive_poly(64, 64);
        wait_drain(500);
        check("after reset word count", 64'(words_seen - w0), 64'd40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
